// File: rtl/da_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : da_pkg
//  Purpose  : Shared types and helpers for the DA bit-plane generator.
//  Revision : 1.0 - initial release
// ============================================================================
package da_pkg;

    // Widest activation element the plane helper can slice.
    localparam int PLANE_MAX_W = 64;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Bit t of value; on the MSB plane the bit is inverted so that the
    // two's-complement sign bit becomes an offset-binary digit.
    function automatic logic plane_bit(
        input logic [PLANE_MAX_W-1:0] value,
        input logic [7:0]             t,
        input logic [7:0]             msb_idx
    );
        logic [PLANE_MAX_W-1:0] shifted;
        shifted = value >> t;
        return shifted[0] ^ (t == msb_idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/da_vec_buf.sv
`default_nettype none
// ============================================================================
//  Module   : da_vec_buf
//  Purpose  : Active/shadow vector register pair with shadow-full flag.
//             Exposes the next-cycle active contents so the top can compute
//             registered plane outputs in the same cycle the vector lands.
//  Revision : 1.0 - initial release
// ============================================================================
module da_vec_buf
    import da_pkg::*;
#(
    parameter int DATA_WIDTH_A = 16,
    parameter int DATA_WIDTH_B = 16,
    parameter int K            = 9
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_act_i,
    input  logic                           load_shd_i,
    input  logic                           promote_i,
    input  logic signed [DATA_WIDTH_A-1:0] a_i [K],
    input  logic signed [DATA_WIDTH_B-1:0] b_i [K],
    output logic signed [DATA_WIDTH_A-1:0] act_a_d_o [K],
    output logic signed [DATA_WIDTH_B-1:0] act_b_d_o [K],
    output logic                           shd_full_q_o,
    output logic                           shd_full_d_o
);

    logic signed [DATA_WIDTH_A-1:0] act_a_q [K];
    logic signed [DATA_WIDTH_B-1:0] act_b_q [K];
    logic signed [DATA_WIDTH_A-1:0] shd_a_q [K];
    logic signed [DATA_WIDTH_B-1:0] shd_b_q [K];
    logic                           shd_full_q;
    logic                           shd_full_d;

    // Next active contents: a direct load wins over promotion (never both).
    always_comb begin
        for (int i = 0; i < K; i++) begin
            act_a_d_o[i] = act_a_q[i];
            act_b_d_o[i] = act_b_q[i];
            if (load_act_i) begin
                act_a_d_o[i] = a_i[i];
                act_b_d_o[i] = b_i[i];
            end else if (promote_i) begin
                act_a_d_o[i] = shd_a_q[i];
                act_b_d_o[i] = shd_b_q[i];
            end
        end
    end

    // Shadow occupancy: promotion empties it, a shadow load fills it.
    always_comb begin
        shd_full_d = shd_full_q;
        if (promote_i) begin
            shd_full_d = 1'b0;
        end
        if (load_shd_i) begin
            shd_full_d = 1'b1;
        end
    end

    // Register the active/shadow pair; reset discards both vectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            shd_full_q <= 1'b0;
            for (int i = 0; i < K; i++) begin
                act_a_q[i] <= '0;
                act_b_q[i] <= '0;
                shd_a_q[i] <= '0;
                shd_b_q[i] <= '0;
            end
        end else begin
            shd_full_q <= shd_full_d;
            for (int i = 0; i < K; i++) begin
                act_a_q[i] <= act_a_d_o[i];
                act_b_q[i] <= act_b_d_o[i];
                if (load_shd_i) begin
                    shd_a_q[i] <= a_i[i];
                    shd_b_q[i] <= b_i[i];
                end
            end
        end
    end

    assign shd_full_q_o = shd_full_q;
    assign shd_full_d_o = shd_full_d;

endmodule
`default_nettype wire

// File: rtl/da_bitplane_gen.sv
`default_nettype none
// ============================================================================
//  Module   : da_bitplane_gen
//  Purpose  : Streams an activation vector as offset-binary bit planes (LSB
//             first) for a distributed-arithmetic LUT stage, holding the
//             weights steady, with a shadow slot for bubble-free streaming.
//  Revision : 1.0 - initial release
// ============================================================================
module da_bitplane_gen
    import da_pkg::*;
#(
    parameter int DATA_WIDTH_A = 16,
    parameter int DATA_WIDTH_B = 16,
    parameter int K            = 9
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_WIDTH_A-1:0] A_in [K],
    input  logic signed [DATA_WIDTH_B-1:0] B_in [K],
    output logic                           gen_done,
    output logic                           A0,
    output logic [K-2:0]                   addr_array,
    output logic signed [DATA_WIDTH_B-1:0] B_temp [K],
    output logic [7:0]                     t,
    output logic                           last,
    output logic                           busy
);

    localparam logic [7:0] c_T_LAST = 8'(DATA_WIDTH_A - 1);

    state_e                         state_q;
    state_e                         state_d;
    logic [7:0]                     t_q;
    logic [7:0]                     t_d;

    logic                           w_accept;
    logic                           w_load_act;
    logic                           w_load_shd;
    logic                           w_promote;
    logic                           w_shd_full_q;
    logic                           w_shd_full_d;
    logic signed [DATA_WIDTH_A-1:0] w_act_a_d [K];
    logic signed [DATA_WIDTH_B-1:0] w_act_b_d [K];
    logic [PLANE_MAX_W-1:0]         w_ext;
    logic [K-1:0]                   w_plane;
    logic [K-2:0]                   w_addr;
    logic                           w_stream_d;

    logic                           in_ready_q;
    logic                           gen_done_q;
    logic                           a0_q;
    logic [K-2:0]                   addr_q;
    logic                           last_q;
    logic                           busy_q;
    logic signed [DATA_WIDTH_B-1:0] b_temp_q [K];

    assign w_accept   = in_valid & in_ready_q;
    assign w_stream_d = (state_d == STREAM);

    da_vec_buf #(
        .DATA_WIDTH_A (DATA_WIDTH_A),
        .DATA_WIDTH_B (DATA_WIDTH_B),
        .K            (K)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .load_act_i   (w_load_act),
        .load_shd_i   (w_load_shd),
        .promote_i    (w_promote),
        .a_i          (A_in),
        .b_i          (B_in),
        .act_a_d_o    (w_act_a_d),
        .act_b_d_o    (w_act_b_d),
        .shd_full_q_o (w_shd_full_q),
        .shd_full_d_o (w_shd_full_d)
    );

    // State and plane-index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // Next state, next plane index and buffer controls.
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        w_load_act = 1'b0;
        w_load_shd = 1'b0;
        w_promote  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    w_load_act = 1'b1;
                    state_d    = STREAM;
                    t_d        = '0;
                end
            end
            STREAM: begin
                if (t_q == c_T_LAST) begin
                    t_d = '0;
                    if (w_shd_full_q) begin
                        // in_ready is low here, so nothing can be accepted.
                        w_promote = 1'b1;
                    end else if (w_accept) begin
                        // Shadow empty: the new vector goes straight to active.
                        w_load_act = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    t_d = t_q + 8'd1;
                    if (w_accept) begin
                        w_load_shd = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Plane bits of the next-cycle active vector at the next plane index.
    always_comb begin
        w_ext   = '0;
        w_plane = '0;
        w_addr  = '0;
        for (int i = 0; i < K; i++) begin
            w_ext                   = '0;
            w_ext[DATA_WIDTH_A-1:0] = w_act_a_d[i];
            w_plane[i]              = plane_bit(w_ext, t_d, c_T_LAST);
        end
        for (int j = 0; j < K - 1; j++) begin
            w_addr[j] = ~(w_plane[j+1] ^ w_plane[0]);
        end
    end

    // Registered outputs; plane outputs are forced to zero outside STREAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b1;
            gen_done_q <= 1'b0;
            a0_q       <= 1'b0;
            addr_q     <= '0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < K; i++) begin
                b_temp_q[i] <= '0;
            end
        end else begin
            in_ready_q <= ~w_shd_full_d;
            gen_done_q <= w_stream_d;
            a0_q       <= w_stream_d ? w_plane[0] : 1'b0;
            addr_q     <= w_stream_d ? w_addr : '0;
            last_q     <= w_stream_d && (t_d == c_T_LAST);
            busy_q     <= w_stream_d | w_shd_full_d;
            if (w_stream_d) begin
                for (int i = 0; i < K; i++) begin
                    b_temp_q[i] <= w_act_b_d[i];
                end
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign gen_done   = gen_done_q;
    assign A0         = a0_q;
    assign addr_array = addr_q;
    assign t          = t_q;
    assign last       = last_q;
    assign busy       = busy_q;
    assign B_temp     = b_temp_q;

endmodule
`default_nettype wire
